// File: rtl/ysyx_23060025_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060025_bus_arbiter
//
// Shares the core's single memory bus between the instruction-fetch unit
// (IFU, read-only) and the load/store unit (LSU, read/write). The LSU has
// fixed priority, but a starvation counter forces an IFU grant after
// STARVE_LIMIT consecutive LSU grants made while the IFU was waiting. The
// downstream request is registered. A transaction that gets no response
// within TIMEOUT_CYCLES ends with an error pulse to the master that owns it.
//
// Ports:
//   clock, rstn       clock and synchronous active-low reset
//   ifu_psel/paddr    IFU read request (held until ifu_pvalid)
//   ifu_prdata/pvalid/perr   IFU response (perr qualified by pvalid)
//   lsu_psel/pwrite/paddr/psize/pwdata/pwstrb   LSU request (held until lsu_pvalid)
//   lsu_prdata/pvalid/perr   LSU response (perr qualified by pvalid)
//   m_psel/pwrite/paddr/psize/pwdata/pwstrb     registered downstream request
//   m_prdata/m_pvalid        downstream response
// ---------------------------------------------------------------------------
module ysyx_23060025_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned STARVE_LIMIT   = 4
) (
   input  logic        clock,
   input  logic        rstn,
   input  logic        ifu_psel,
   input  logic [31:0] ifu_paddr,
   output logic [31:0] ifu_prdata,
   output logic        ifu_pvalid,
   output logic        ifu_perr,
   input  logic        lsu_psel,
   input  logic        lsu_pwrite,
   input  logic [31:0] lsu_paddr,
   input  logic [2:0]  lsu_psize,
   input  logic [31:0] lsu_pwdata,
   input  logic [3:0]  lsu_pwstrb,
   output logic [31:0] lsu_prdata,
   output logic        lsu_pvalid,
   output logic        lsu_perr,
   output logic        m_psel,
   output logic        m_pwrite,
   output logic [31:0] m_paddr,
   output logic [2:0]  m_psize,
   output logic [31:0] m_pwdata,
   output logic [3:0]  m_pwstrb,
   input  logic [31:0] m_prdata,
   input  logic        m_pvalid
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_IFU,
      BUSY_LSU,
      ERR
   } state_t;

   localparam logic [7:0]  STARVE_MAX  = 8'(STARVE_LIMIT);
   localparam logic [16:0] TIMEOUT_MAX = 17'(TIMEOUT_CYCLES);

   state_t      state;
   state_t      state_next;
   logic [7:0]  starve_cnt;
   logic [15:0] timeout_cnt;
   logic        err_lsu;
   logic        grant_lsu;
   logic        grant_ifu;
   logic        timeout_hit;

   // Arbitration: the LSU wins unless the IFU is waiting and has already been
   // passed over STARVE_LIMIT times in a row. The timeout fires on the busy
   // cycle whose increment would bring the counter up to TIMEOUT_CYCLES, so
   // the error pulse lands exactly TIMEOUT_CYCLES cycles after m_psel rose.
   always_comb begin
      grant_lsu   = (state == IDLE) && lsu_psel && !(ifu_psel && (starve_cnt == STARVE_MAX));
      grant_ifu   = (state == IDLE) && ifu_psel && !grant_lsu;
      timeout_hit = (TIMEOUT_CYCLES != 0) && ((17'(timeout_cnt) + 17'd1) == TIMEOUT_MAX);
   end

   // Next-state logic. A response in the same cycle as the timeout limit wins,
   // so m_pvalid is tested before timeout_hit.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (grant_lsu) begin
               state_next = BUSY_LSU;
            end else if (grant_ifu) begin
               state_next = BUSY_IFU;
            end
         end
         BUSY_IFU, BUSY_LSU: begin
            if (m_pvalid) begin
               state_next = IDLE;
            end else if (timeout_hit) begin
               state_next = ERR;
            end
         end
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Upstream responses are combinational so a downstream completion reaches
   // the owner with no added latency. They are held at zero while reset is
   // asserted so an abandoned transaction never produces a completion.
   always_comb begin
      ifu_prdata = 32'd0;
      ifu_pvalid = 1'b0;
      ifu_perr   = 1'b0;
      lsu_prdata = 32'd0;
      lsu_pvalid = 1'b0;
      lsu_perr   = 1'b0;
      if (rstn) begin
         case (state)
            BUSY_IFU: begin
               if (m_pvalid) begin
                  ifu_pvalid = 1'b1;
                  ifu_prdata = m_prdata;
               end
            end
            BUSY_LSU: begin
               if (m_pvalid) begin
                  lsu_pvalid = 1'b1;
                  lsu_prdata = m_prdata;
               end
            end
            ERR: begin
               if (err_lsu) begin
                  lsu_pvalid = 1'b1;
                  lsu_perr   = 1'b1;
               end else begin
                  ifu_pvalid = 1'b1;
                  ifu_perr   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // State, counters and the registered downstream request. Attributes are
   // captured only on a grant, so they stay stable for the whole transaction
   // no matter what the masters do with their inputs meanwhile. err_lsu
   // remembers the owner so the ERR cycle knows whom to answer.
   always_ff @(posedge clock) begin
      if (!rstn) begin
         state       <= IDLE;
         starve_cnt  <= 8'd0;
         timeout_cnt <= 16'd0;
         err_lsu     <= 1'b0;
         m_psel      <= 1'b0;
         m_pwrite    <= 1'b0;
         m_paddr     <= 32'd0;
         m_psize     <= 3'd0;
         m_pwdata    <= 32'd0;
         m_pwstrb    <= 4'd0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (grant_lsu) begin
                  m_psel      <= 1'b1;
                  m_pwrite    <= lsu_pwrite;
                  m_paddr     <= lsu_paddr;
                  m_psize     <= lsu_psize;
                  m_pwdata    <= lsu_pwdata;
                  m_pwstrb    <= lsu_pwstrb;
                  timeout_cnt <= 16'd0;
                  err_lsu     <= 1'b1;
                  if (ifu_psel && (starve_cnt != STARVE_MAX)) begin
                     starve_cnt <= starve_cnt + 8'd1;
                  end
               end else if (grant_ifu) begin
                  m_psel      <= 1'b1;
                  m_pwrite    <= 1'b0;
                  m_paddr     <= ifu_paddr;
                  m_psize     <= 3'b010;
                  m_pwdata    <= 32'd0;
                  m_pwstrb    <= 4'd0;
                  timeout_cnt <= 16'd0;
                  err_lsu     <= 1'b0;
                  starve_cnt  <= 8'd0;
               end
            end
            BUSY_IFU, BUSY_LSU: begin
               if (m_pvalid || timeout_hit) begin
                  m_psel <= 1'b0;
               end else begin
                  timeout_cnt <= timeout_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060025_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060025_bus_arbiter
//
// Drives the arbiter through a set of directed scenarios (single IFU read,
// contention ordering, LSU store with timeout, simultaneous response and
// timeout, reset mid-transaction) and then a long randomized run. A
// transaction-level model of the arbiter is checked against the DUT on every
// cycle by a single compare process.
// ---------------------------------------------------------------------------
module tb_ysyx_23060025_bus_arbiter;

   localparam int unsigned TO = 8;
   localparam int unsigned SL = 4;

   logic        clock = 1'b0;
   logic        rstn;
   logic        ifu_psel;
   logic [31:0] ifu_paddr;
   logic [31:0] ifu_prdata;
   logic        ifu_pvalid;
   logic        ifu_perr;
   logic        lsu_psel;
   logic        lsu_pwrite;
   logic [31:0] lsu_paddr;
   logic [2:0]  lsu_psize;
   logic [31:0] lsu_pwdata;
   logic [3:0]  lsu_pwstrb;
   logic [31:0] lsu_prdata;
   logic        lsu_pvalid;
   logic        lsu_perr;
   logic        m_psel;
   logic        m_pwrite;
   logic [31:0] m_paddr;
   logic [2:0]  m_psize;
   logic [31:0] m_pwdata;
   logic [3:0]  m_pwstrb;
   logic [31:0] m_prdata;
   logic        m_pvalid;

   ysyx_23060025_bus_arbiter #(
      .TIMEOUT_CYCLES(TO),
      .STARVE_LIMIT  (SL)
   ) dut (
      .clock     (clock),
      .rstn      (rstn),
      .ifu_psel  (ifu_psel),
      .ifu_paddr (ifu_paddr),
      .ifu_prdata(ifu_prdata),
      .ifu_pvalid(ifu_pvalid),
      .ifu_perr  (ifu_perr),
      .lsu_psel  (lsu_psel),
      .lsu_pwrite(lsu_pwrite),
      .lsu_paddr (lsu_paddr),
      .lsu_psize (lsu_psize),
      .lsu_pwdata(lsu_pwdata),
      .lsu_pwstrb(lsu_pwstrb),
      .lsu_prdata(lsu_prdata),
      .lsu_pvalid(lsu_pvalid),
      .lsu_perr  (lsu_perr),
      .m_psel    (m_psel),
      .m_pwrite  (m_pwrite),
      .m_paddr   (m_paddr),
      .m_psize   (m_psize),
      .m_pwdata  (m_pwdata),
      .m_pwstrb  (m_pwstrb),
      .m_prdata  (m_prdata),
      .m_pvalid  (m_pvalid)
   );

   // Free-running clock, first rising edge at t=5.
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Model state: who owns the bus (0 none, 1 IFU, 2 LSU), who is owed an
   // error pulse this cycle, the cycle the transaction's bus phase started,
   // the consecutive LSU wins over a waiting IFU, and the latched request.
   int          cyc        = 0;
   bit          modelReady = 1'b0;
   int          owner      = 0;
   int          errOwner   = 0;
   int          startCyc   = 0;
   int          starve     = 0;
   logic        mSelE;
   logic        mWriteE;
   logic [31:0] mAddrE;
   logic [2:0]  mSizeE;
   logic [31:0] mWdataE;
   logic [3:0]  mStrbE;
   bit          expIfuValid = 1'b0;
   bit          expLsuValid = 1'b0;
   int          slavePct    = 50;

   logic        eIv, eIe, eLv, eLe;
   logic [31:0] eIr, eLr;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   // Random masters and slave for one cycle. A master keeps its request up
   // until it saw a completion, then either issues a new access or goes quiet.
   // Attributes change every cycle to prove the arbiter latches them.
   task automatic applyStimulus();
      if (ifu_psel) begin
         if (expIfuValid) ifu_psel = ($urandom_range(99) < 30);
      end else begin
         ifu_psel = ($urandom_range(99) < 40);
      end
      if (lsu_psel) begin
         if (expLsuValid) lsu_psel = ($urandom_range(99) < 30);
      end else begin
         lsu_psel = ($urandom_range(99) < 40);
      end
      ifu_paddr  = $urandom;
      lsu_pwrite = 1'($urandom_range(1));
      lsu_paddr  = $urandom;
      lsu_psize  = 3'($urandom_range(7));
      lsu_pwdata = $urandom;
      lsu_pwstrb = 4'($urandom_range(15));
      m_pvalid   = ($urandom_range(99) < slavePct);
      m_prdata   = $urandom;
   endtask

   // Compare process: at each falling edge derive what the arbiter must show
   // this cycle from the transaction model, compare, then advance the model.
   always @(negedge clock) begin
      cyc++;
      if (!rstn) begin
         owner       = 0;
         errOwner    = 0;
         starve      = 0;
         mSelE       = 1'b0;
         mWriteE     = 1'b0;
         mAddrE      = 32'd0;
         mSizeE      = 3'd0;
         mWdataE     = 32'd0;
         mStrbE      = 4'd0;
         expIfuValid = 1'b0;
         expLsuValid = 1'b0;
         modelReady  = 1'b1;
      end else if (modelReady) begin
         eIv = 1'b0; eIe = 1'b0; eIr = 32'd0;
         eLv = 1'b0; eLe = 1'b0; eLr = 32'd0;
         if (errOwner == 1) begin
            eIv = 1'b1; eIe = 1'b1;
         end else if (errOwner == 2) begin
            eLv = 1'b1; eLe = 1'b1;
         end else if (owner == 1 && m_pvalid) begin
            eIv = 1'b1; eIr = m_prdata;
         end else if (owner == 2 && m_pvalid) begin
            eLv = 1'b1; eLr = m_prdata;
         end

         checkOutput("ifu_pvalid", 32'(ifu_pvalid), 32'(eIv));
         checkOutput("lsu_pvalid", 32'(lsu_pvalid), 32'(eLv));
         if (eIv || (owner != 1 && errOwner != 1)) begin
            checkOutput("ifu_perr", 32'(ifu_perr), 32'(eIe));
            checkOutput("ifu_prdata", ifu_prdata, eIr);
         end
         if (eLv || (owner != 2 && errOwner != 2)) begin
            checkOutput("lsu_perr", 32'(lsu_perr), 32'(eLe));
            checkOutput("lsu_prdata", lsu_prdata, eLr);
         end
         checkOutput("m_psel", 32'(m_psel), 32'(mSelE));
         if (mSelE) begin
            checkOutput("m_pwrite", 32'(m_pwrite), 32'(mWriteE));
            checkOutput("m_paddr", m_paddr, mAddrE);
            checkOutput("m_psize", 32'(m_psize), 32'(mSizeE));
            checkOutput("m_pwdata", m_pwdata, mWdataE);
            checkOutput("m_pwstrb", 32'(m_pwstrb), 32'(mStrbE));
         end
         expIfuValid = eIv;
         expLsuValid = eLv;

         if (errOwner != 0) begin
            errOwner = 0;
         end else if (owner != 0) begin
            if (m_pvalid) begin
               owner = 0;
               mSelE = 1'b0;
            end else if (TO != 0 && (cyc - startCyc + 1) == int'(TO)) begin
               errOwner = owner;
               owner    = 0;
               mSelE    = 1'b0;
            end
         end else if (lsu_psel && !(ifu_psel && starve == int'(SL))) begin
            owner    = 2;
            startCyc = cyc + 1;
            if (ifu_psel && starve < int'(SL)) starve++;
            mSelE   = 1'b1;
            mWriteE = lsu_pwrite;
            mAddrE  = lsu_paddr;
            mSizeE  = lsu_psize;
            mWdataE = lsu_pwdata;
            mStrbE  = lsu_pwstrb;
         end else if (ifu_psel) begin
            owner    = 1;
            startCyc = cyc + 1;
            starve   = 0;
            mSelE    = 1'b1;
            mWriteE  = 1'b0;
            mAddrE   = ifu_paddr;
            mSizeE   = 3'b010;
            mWdataE  = 32'd0;
            mStrbE   = 4'd0;
         end
      end
   end

   // Directed scenarios with hand-computed expectations, then random traffic.
   initial begin
      rstn = 1'b0;
      ifu_psel = 1'b0; ifu_paddr = 32'd0;
      lsu_psel = 1'b0; lsu_pwrite = 1'b0; lsu_paddr = 32'd0;
      lsu_psize = 3'd0; lsu_pwdata = 32'd0; lsu_pwstrb = 4'd0;
      m_pvalid = 1'b0; m_prdata = 32'd0;
      repeat (3) stepCycle();

      // Single IFU read answered 3 cycles after m_psel rises.
      rstn = 1'b1; ifu_psel = 1'b1; ifu_paddr = 32'h3000_0000;
      stepCycle(); #1;
      checkOutput("ifu m_psel", 32'(m_psel), 32'd1);
      checkOutput("ifu m_paddr", m_paddr, 32'h3000_0000);
      checkOutput("ifu m_psize", 32'(m_psize), 32'd2);
      checkOutput("ifu m_pwrite", 32'(m_pwrite), 32'd0);
      checkOutput("ifu m_pwstrb", 32'(m_pwstrb), 32'd0);
      stepCycle(); stepCycle(); stepCycle();
      m_pvalid = 1'b1; m_prdata = 32'hDEAD_BEEF; #1;
      checkOutput("ifu rd pvalid", 32'(ifu_pvalid), 32'd1);
      checkOutput("ifu rd prdata", ifu_prdata, 32'hDEAD_BEEF);
      checkOutput("ifu rd perr", 32'(ifu_perr), 32'd0);
      checkOutput("ifu rd lsu_pvalid", 32'(lsu_pvalid), 32'd0);
      stepCycle();
      ifu_psel = 1'b0; m_pvalid = 1'b0; m_prdata = 32'd0;
      stepCycle();

      // Contention with a 1-cycle slave: LSU,LSU,LSU,LSU,IFU repeating.
      ifu_psel = 1'b1; ifu_paddr = 32'h3000_0100;
      lsu_psel = 1'b1; lsu_pwrite = 1'b0; lsu_paddr = 32'h8000_0100;
      lsu_psize = 3'b010; lsu_pwdata = 32'd0; lsu_pwstrb = 4'd0;
      m_pvalid = 1'b1; m_prdata = 32'h1111_2222;
      for (int k = 0; k < 10; k++) begin
         stepCycle(); #1;
         checkOutput("order lsu_pvalid", 32'(lsu_pvalid), (k % 5 == 4) ? 32'd0 : 32'd1);
         checkOutput("order ifu_pvalid", 32'(ifu_pvalid), (k % 5 == 4) ? 32'd1 : 32'd0);
         stepCycle();
      end
      ifu_psel = 1'b0; lsu_psel = 1'b0; m_pvalid = 1'b0;
      stepCycle();

      // LSU byte store, inputs toggling after grant, slave never answers.
      lsu_psel = 1'b1; lsu_pwrite = 1'b1; lsu_paddr = 32'h8000_0003;
      lsu_psize = 3'b000; lsu_pwdata = 32'h5A5A_5A5A; lsu_pwstrb = 4'b1000;
      for (int k = 1; k <= 8; k++) begin
         stepCycle(); #1;
         checkOutput("store m_psel", 32'(m_psel), 32'd1);
         checkOutput("store m_pwrite", 32'(m_pwrite), 32'd1);
         checkOutput("store m_paddr", m_paddr, 32'h8000_0003);
         checkOutput("store m_psize", 32'(m_psize), 32'd0);
         checkOutput("store m_pwdata", m_pwdata, 32'h5A5A_5A5A);
         checkOutput("store m_pwstrb", 32'(m_pwstrb), 32'b1000);
         checkOutput("store no early pvalid", 32'(lsu_pvalid), 32'd0);
         lsu_pwrite = ~lsu_pwrite; lsu_paddr = $urandom;
         lsu_pwdata = ~lsu_pwdata; lsu_pwstrb = ~lsu_pwstrb; lsu_psize = 3'(k);
      end
      stepCycle();
      m_pvalid = 1'b1; m_prdata = 32'hCAFE_F00D; #1;
      checkOutput("timeout lsu_pvalid", 32'(lsu_pvalid), 32'd1);
      checkOutput("timeout lsu_perr", 32'(lsu_perr), 32'd1);
      checkOutput("timeout lsu_prdata", lsu_prdata, 32'd0);
      checkOutput("timeout m_psel", 32'(m_psel), 32'd0);
      checkOutput("timeout ifu_pvalid", 32'(ifu_pvalid), 32'd0);
      stepCycle();
      lsu_psel = 1'b0; #1;
      checkOutput("late rsp lsu_pvalid", 32'(lsu_pvalid), 32'd0);
      checkOutput("late rsp ifu_pvalid", 32'(ifu_pvalid), 32'd0);
      m_pvalid = 1'b0;
      stepCycle();

      // Response in the very cycle the timeout limit is reached.
      lsu_psel = 1'b1; lsu_pwrite = 1'b0; lsu_paddr = 32'h0000_1000;
      lsu_psize = 3'b010; lsu_pwstrb = 4'd0;
      repeat (7) stepCycle();
      stepCycle();
      m_pvalid = 1'b1; m_prdata = 32'h600D_F00D; #1;
      checkOutput("edge lsu_pvalid", 32'(lsu_pvalid), 32'd1);
      checkOutput("edge lsu_perr", 32'(lsu_perr), 32'd0);
      checkOutput("edge lsu_prdata", lsu_prdata, 32'h600D_F00D);
      stepCycle();
      lsu_psel = 1'b0; m_pvalid = 1'b0; #1;
      checkOutput("edge no err pulse", 32'(lsu_pvalid), 32'd0);
      stepCycle();

      // Reset while the LSU owns the bus, then a normal IFU read.
      lsu_psel = 1'b1; lsu_pwrite = 1'b1; lsu_paddr = 32'h2000_0010;
      lsu_pwdata = 32'h1234_5678; lsu_pwstrb = 4'hF;
      stepCycle();
      stepCycle();
      rstn = 1'b0;
      stepCycle(); #1;
      checkOutput("rst m_psel", 32'(m_psel), 32'd0);
      checkOutput("rst m_paddr", m_paddr, 32'd0);
      checkOutput("rst m_pwdata", m_pwdata, 32'd0);
      checkOutput("rst m_pwstrb", 32'(m_pwstrb), 32'd0);
      checkOutput("rst m_pwrite", 32'(m_pwrite), 32'd0);
      checkOutput("rst lsu_pvalid", 32'(lsu_pvalid), 32'd0);
      checkOutput("rst ifu_pvalid", 32'(ifu_pvalid), 32'd0);
      lsu_psel = 1'b0;
      stepCycle();
      rstn = 1'b1; ifu_psel = 1'b1; ifu_paddr = 32'h3000_0040;
      stepCycle(); #1;
      checkOutput("post-rst m_psel", 32'(m_psel), 32'd1);
      checkOutput("post-rst m_paddr", m_paddr, 32'h3000_0040);
      m_pvalid = 1'b1; m_prdata = 32'h0BAD_CAFE; #1;
      checkOutput("post-rst ifu_pvalid", 32'(ifu_pvalid), 32'd1);
      checkOutput("post-rst ifu_prdata", ifu_prdata, 32'h0BAD_CAFE);
      checkOutput("post-rst lsu_pvalid", 32'(lsu_pvalid), 32'd0);
      stepCycle();
      ifu_psel = 1'b0; m_pvalid = 1'b0;
      stepCycle();

      // Random traffic: normal, slow (timeouts likely) and fast slave phases.
      for (int i = 0; i < 3000; i++) begin
         slavePct = (i < 1000) ? 50 : ((i < 2000) ? 10 : 90);
         stepCycle();
         applyStimulus();
      end
      stepCycle();
      ifu_psel = 1'b0; lsu_psel = 1'b0; m_pvalid = 1'b0;
      repeat (3) stepCycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_23060025_bus_arbiter.md
# ysyx_23060025_bus_arbiter

Two-master, one-slave arbiter that shares the core's single memory bus between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It sits between the IFU/LSU memory ports and the downstream bus bridge. It provides:
- fixed LSU priority with an IFU starvation guard;
- a registered downstream request;
- a response timeout that returns an error to the owning master.

## Interface
- `TIMEOUT_CYCLES`, default 1024: cycles `m_psel` may stay high without `m_pvalid`. Range 0..65535; 0 disables the timeout.
- `STARVE_LIMIT`, default 4: consecutive LSU grants allowed while IFU waits. Range 1..255.
- `clock`  in  1  clock
- `rstn`  in  1  reset, synchronous, active-low
- `ifu_psel`  in  1  IFU read request, held until `ifu_pvalid`
- `ifu_paddr`  in  32  IFU address
- `ifu_prdata`  out  32  IFU read data
- `ifu_pvalid`  out  1  IFU completion pulse
- `ifu_perr`  out  1  IFU error, qualified by `ifu_pvalid`
- `lsu_psel`  in  1  LSU request, held until `lsu_pvalid`
- `lsu_pwrite`  in  1  1 = store
- `lsu_paddr`  in  32  LSU address
- `lsu_psize`  in  3  size code, forwarded unchanged
- `lsu_pwdata`  in  32  store data
- `lsu_pwstrb`  in  4  byte strobes
- `lsu_prdata`  out  32  LSU read data
- `lsu_pvalid`  out  1  LSU completion pulse
- `lsu_perr`  out  1  LSU error, qualified by `lsu_pvalid`
- `m_psel, m_pwrite`  out  1 each  downstream request, registered
- `m_paddr`  out  32  downstream address
- `m_psize`  out  3  downstream size code
- `m_pwdata`  out  32  downstream store data
- `m_pwstrb`  out  4  downstream byte strobes
- `m_prdata`  in  32  downstream read data
- `m_pvalid`  in  1  downstream completion pulse

## Operation
- **FSM states:** `IDLE`, `BUSY_IFU`, `BUSY_LSU`, `ERR`.
- **IDLE arbitration:**
  - Only LSU requests: grant LSU.
  - Only IFU requests: grant IFU.
  - Both request: grant LSU unless `starve_cnt == STARVE_LIMIT`, in which case grant IFU.
- **Starvation counter (8-bit `starve_cnt`):**
  - +1 on each LSU grant made while `ifu_psel` is high.
  - Cleared on every IFU grant.
  - Saturates at `STARVE_LIMIT`.
- **Request latching on grant:** the granted master's attributes are latched into the `m_*` registers, `m_psel` is set, and the timeout counter is cleared.
  - IFU grant drives `m_pwrite=0`, `m_psize=3'b010`, `m_pwdata=0`, `m_pwstrb=0`.
  - Attributes stay stable for the whole transaction, whatever the inputs do.
- **BUSY_x:**
  - `m_pvalid=1`: owner gets `pvalid=1`, `perr=0`, `prdata=m_prdata` combinationally in the same cycle. `m_psel` clears, and the FSM goes to `IDLE`.
  - Otherwise the timeout counter (16-bit) increments.
  - If `TIMEOUT_CYCLES != 0` and the counter reaches `TIMEOUT_CYCLES` without `m_pvalid`, the FSM goes to `ERR` and `m_psel` clears.
- **ERR:** lasts one cycle. Owner gets `pvalid=1`, `perr=1`, `prdata=0`. Next state is `IDLE`.
- **Non-owner outputs:** the non-owner's `pvalid`, `perr` and `prdata` are always 0.
- **Late responses:** `m_pvalid` arriving in `IDLE` or `ERR` is ignored.
- **Re-request after completion:** a master whose `psel` is still high in the cycle after its `pvalid` starts a new transaction. Requesters drop `psel` on completion unless they issue a new access.
- **Reset:**
  - Next edge gives `IDLE`, counters 0, all `m_*` 0, all upstream outputs 0.
  - Reset mid-transaction abandons it; no upstream `pvalid` is generated for it.

## Timing
- **Grant latency:** `psel` seen in `IDLE` at cycle T gives `m_psel=1` at T+1.
- **Response latency:** zero added. `m_pvalid` at cycle R gives the upstream `pvalid` at R.
- **Back-to-back:** next grant is evaluated at R+1, giving the next `m_psel` at R+2. There is one dead bus cycle between transactions.
- **Timeout:** with `m_psel` first high at T+1 and no response, the error pulse arrives at `T+1+TIMEOUT_CYCLES`.
- **Simultaneous events:** `m_pvalid` in the same cycle the counter hits the limit counts as success (`perr=0`).

## Test plan
- **Single IFU read:** `ifu_psel=1`, `ifu_paddr=0x3000_0000`, slave answers 3 cycles after `m_psel` with `0xDEADBEEF` -> `m_psize=3'b010`, `m_pwrite=0`; `ifu_pvalid` with `ifu_prdata=0xDEADBEEF`, `ifu_perr=0`, in the same cycle as `m_pvalid`.
- **LSU byte store:** `lsu_pwrite=1`, `lsu_paddr=0x8000_0003`, `lsu_pwstrb=4'b1000`, `lsu_pwdata=0x5A5A5A5A` -> `m_*` match the inputs exactly and stay stable while the inputs toggle after the grant.
- **Contention:** both request continuously, `STARVE_LIMIT=4`, 1-cycle slave -> grant order LSU, LSU, LSU, LSU, IFU, repeating.
- **Timeout:** `TIMEOUT_CYCLES=8`, slave never responds -> `lsu_pvalid=1`, `lsu_perr=1`, `lsu_prdata=0` exactly 8 cycles after `m_psel` rose, with `m_psel=0` in that cycle. A late `m_pvalid` afterwards produces no upstream pulse.
- **Reset mid-transaction:** `rstn=0` while in `BUSY_LSU` -> next cycle all outputs 0, no `lsu_pvalid`; after reset release an IFU request is granted normally.
- **Same-cycle success and timeout:** `m_pvalid` in the cycle the timeout counter reaches its limit -> success response (`perr=0`), no `ERR` cycle.
